btn_conditioner: RTL and testbench

//  Input stage ahead of the game-update logic: synchronises, debounces and conditions btnL/btnR/btnU.

---
 rtl/astro_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 97 +++++++++
 rtl/btn_conditioner.sv | 115 +++++++++++
 tb/tb_btn_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/astro_pkg.sv
// Shared types for the button input stage: debounce state encoding,
// button index constants and the left/right move decode.
package astro_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_R   = 1;
  localparam int unsigned BTN_U   = 2;
  localparam int unsigned NUM_BTN = 3;

  // Returns {move_right, move_left}; opposing directions cancel each other.
  function automatic logic [1:0] move_decode(input logic left_i, input logic right_i);
    return {right_i & ~left_i, left_i & ~right_i};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer feeding a four-state debounce FSM
// with a saturating stability counter. level and rise are registered.
module btn_debounce
  import astro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic board_clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  // The sample that leaves IDLE/PRESSED is the first stable one, so the
  // terminal value is reached on the DEBOUNCE_CYCLES-th stable sample.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       sync_q;
  logic             sync_s;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             rise_q;

  assign sync_s = sync_q[1];

  // Saturating increment of the stability counter
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchronizer, debounce FSM, counter and registered outputs
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_s) begin
            state_q <= IDLE;
          end else if (cnt_d == CNT_TERM) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        PRESSED: begin
          if (!sync_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_s) begin
            state_q <= PRESSED;
          end else if (cnt_d == CNT_TERM) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner: debounced move levels plus a sticky shoot request held
// until game_tick consumes it. Define AUTOFIRE_EN to re-arm shots while fire is held.
module btn_conditioner
  import astro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
`ifdef AUTOFIRE_EN
  ,
  parameter int unsigned AUTOFIRE_TICKS  = 8
`endif
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       game_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       shoot_req,
  output logic [2:0] btn_dbg
);

  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [1:0]         move_q;
  logic               shoot_q;
  logic               shoot_d;
  logic               af_fire_s;
  logic               unused_rise_s;

  assign raw_s = {btnU, btnR, btnL};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .board_clk(board_clk),
      .reset    (reset),
      .raw      (raw_s[i]),
      .level    (level_s[i]),
      .rise     (rise_s[i])
    );
  end

  // Only the fire button's edge matters; move buttons are used as levels.
  assign unused_rise_s = rise_s[BTN_L] | rise_s[BTN_R];

`ifdef AUTOFIRE_EN
  localparam int unsigned AF_W = $clog2(AUTOFIRE_TICKS + 1);
  logic [AF_W-1:0] af_q;
  logic [AF_W-1:0] af_d;

  // Count game ticks since the last set while fire stays held
  always_comb begin
    af_d      = af_q;
    af_fire_s = 1'b0;
    if (!level_s[BTN_U] || rise_s[BTN_U]) begin
      af_d = '0;
    end else if (game_tick) begin
      if (af_q == AF_W'(AUTOFIRE_TICKS - 1)) begin
        af_d      = '0;
        af_fire_s = 1'b1;
      end else begin
        af_d = af_q + AF_W'(1);
      end
    end else begin
      af_d = af_q;
    end
  end

  // Autofire tick counter register
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      af_q <= '0;
    end else begin
      af_q <= af_d;
    end
  end
`else
  assign af_fire_s = 1'b0;
`endif

  // A new shot wins over consumption in the same cycle; pending shots do not queue.
  always_comb begin
    shoot_d = shoot_q;
    if (rise_s[BTN_U] || af_fire_s) begin
      shoot_d = 1'b1;
    end else if (game_tick && shoot_q) begin
      shoot_d = 1'b0;
    end else begin
      shoot_d = shoot_q;
    end
  end

  // Registered move levels and shoot request
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      move_q  <= 2'b00;
      shoot_q <= 1'b0;
    end else begin
      move_q  <= move_decode(level_s[BTN_L], level_s[BTN_R]);
      shoot_q <= shoot_d;
    end
  end

  assign move_left  = move_q[0];
  assign move_right = move_q[1];
  assign shoot_req  = shoot_q;
  assign btn_dbg    = level_s;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4 (and AUTOFIRE_TICKS=3
// when AUTOFIRE_EN is defined). Inputs driven and outputs sampled on negedge.
module tb_btn_conditioner;

  logic       board_clk = 1'b0;
  logic       reset;
  logic       btnL;
  logic       btnR;
  logic       btnU;
  logic       game_tick;
  logic       move_left;
  logic       move_right;
  logic       shoot_req;
  logic [2:0] btn_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 board_clk = ~board_clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
`ifdef AUTOFIRE_EN
    ,
    .AUTOFIRE_TICKS (3)
`endif
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .btnL      (btnL),
    .btnR      (btnR),
    .btnU      (btnU),
    .game_tick (game_tick),
    .move_left (move_left),
    .move_right(move_right),
    .shoot_req (shoot_req),
    .btn_dbg   (btn_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  // Latency in cycles from the posedge that first samples the raw edge
  // until move_left reads 'want'; 99 when it never does.
  task automatic wait_lat(input logic want, output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (move_left == want) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    logic seen;
    reset = 1'b1; btnL = 1'b0; btnR = 1'b0; btnU = 1'b0; game_tick = 1'b0;
    cyc(2);
    check_eq("reset_out", {move_left, move_right, shoot_req, btn_dbg}, 32'h0);
    reset = 1'b0;
    cyc(3);

    // 3-cycle pulse is rejected
    btnL = 1'b1; cyc(3); btnL = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (move_left || btn_dbg[0]) seen = 1'b1;
    end
    check_eq("glitch_rej", seen, 1'b0);

    // 4-cycle pulse is the shortest accepted press
    btnL = 1'b1; cyc(4); btnL = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (btn_dbg[0]) seen = 1'b1;
    end
    check_eq("min_press", seen, 1'b1);
    cyc(8);

    // Press/release latency of move_left
    btnL = 1'b1;
    wait_lat(1'b1, lat);
    check_eq("rise_lat", lat, 32'd6);
    cyc(3);
    btnL = 1'b0;
    wait_lat(1'b0, lat);
    check_eq("fall_lat", lat, 32'd6);
    cyc(4);

    // Both held cancel; right alone moves right
    btnL = 1'b1; btnR = 1'b1; cyc(10);
    check_eq("both_dbg", btn_dbg, 3'b011);
    check_eq("both_move", {move_left, move_right}, 2'b00);
    btnL = 1'b0; cyc(10);
    check_eq("r_only", {move_left, move_right}, 2'b01);
    btnR = 1'b0; cyc(10);
    check_eq("idle_move", {move_left, move_right, btn_dbg}, 5'b0);

    // Shoot request held without ticks, consumed by one tick
    btnU = 1'b1; cyc(8);
    check_eq("shoot_set", shoot_req, 1'b1);
    cyc(100);
    check_eq("shoot_hold", shoot_req, 1'b1);
    game_tick = 1'b1; cyc(1); game_tick = 1'b0;
    check_eq("shoot_clr", shoot_req, 1'b0);
`ifndef AUTOFIRE_EN
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(9); game_tick = 1'b1; cyc(1); game_tick = 1'b0;
      if (shoot_req) seen = 1'b1;
    end
    check_eq("no_rearm", seen, 1'b0);
`endif
    btnU = 1'b0; cyc(12);

    // Rise coincides with consuming tick: set wins, no second shot queued
    btnU = 1'b1; cyc(8); btnU = 1'b0; cyc(12);
    check_eq("pending", shoot_req, 1'b1);
    btnU = 1'b1; cyc(6);
    game_tick = 1'b1; cyc(1); game_tick = 1'b0;
    check_eq("set_wins", shoot_req, 1'b1);
    cyc(2);
    check_eq("still_pend", shoot_req, 1'b1);
    game_tick = 1'b1; cyc(1); game_tick = 1'b0;
    check_eq("no_queue", shoot_req, 1'b0);
    btnU = 1'b0; cyc(12);

    // Reset mid-press drops the pending request
    btnU = 1'b1; cyc(8);
    check_eq("pre_rst", shoot_req, 1'b1);
    reset = 1'b1; cyc(1);
    check_eq("rst_mid", {move_left, move_right, shoot_req, btn_dbg}, 32'h0);
    btnU = 1'b0; cyc(2);
    reset = 1'b0; cyc(20);
    check_eq("post_rst", {move_left, move_right, shoot_req, btn_dbg}, 32'h0);

`ifdef AUTOFIRE_EN
    // Held fire re-arms the request every third tick
    btnU = 1'b1; cyc(8);
    check_eq("af_first", shoot_req, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc(9); game_tick = 1'b1; cyc(1); game_tick = 1'b0;
      check_eq($sformatf("af_tick%0d", k), shoot_req, (k % 3 == 0) ? 1'b1 : 1'b0);
    end
    btnU = 1'b0; cyc(12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
